// File: rtl/rs_arith.sv
// rs_arith: reservation station for the arithmetic functional unit.
// Holds renamed instructions in an age-ordered collapsing queue, captures
// source values from writeback broadcasts and issues the oldest ready entry.
module rs_arith #(
  parameter int DEPTH  = 4,
  parameter int PRN_W  = 7,
  parameter int ID_W   = 6,
  parameter int NUM_WB = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    disp_valid,
  output logic                    disp_ready,
  input  logic [31:0]             disp_inst,
  input  logic [ID_W-1:0]         disp_inst_id,
  input  logic [3*PRN_W-1:0]      disp_out_prn,
  input  logic [2*PRN_W-1:0]      disp_src_prn,
  input  logic [1:0]              disp_src_rdy,
  input  logic [2*64-1:0]         disp_src_data,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*PRN_W-1:0] wb_prn,
  input  logic [NUM_WB*64-1:0]    wb_data,
  input  logic                    fu_ready,
  output logic                    iss_valid,
  output logic [31:0]             iss_inst,
  output logic [ID_W-1:0]         iss_inst_id,
  output logic [3*PRN_W-1:0]      iss_out_prn,
  output logic [2*64-1:0]         iss_op
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic                       valid;
    logic [31:0]                inst;
    logic [ID_W-1:0]            id;
    logic [3*PRN_W-1:0]         out_prn;
    logic [1:0][PRN_W-1:0]      src_prn;
    logic [1:0]                 src_rdy;
    logic [1:0][63:0]           src_data;
  } entry_t;

  entry_t          ent_q [DEPTH];
  entry_t          ent_d [DEPTH];
  entry_t          woken [DEPTH];
  entry_t          new_ent;
  entry_t          sel_ent;
  logic [CW-1:0]   count_q, count_d, count_after;
  logic            sel_found;
  logic [IW-1:0]   sel_idx;
  logic            accept;

  logic                 iss_valid_q;
  logic [31:0]          iss_inst_q;
  logic [ID_W-1:0]      iss_id_q;
  logic [3*PRN_W-1:0]   iss_out_prn_q;
  logic [2*64-1:0]      iss_op_q;

  assign disp_ready  = (count_q < CW'(DEPTH));
  assign accept      = disp_valid && disp_ready;
  assign iss_valid   = iss_valid_q;
  assign iss_inst    = iss_inst_q;
  assign iss_inst_id = iss_id_q;
  assign iss_out_prn = iss_out_prn_q;
  assign iss_op      = iss_op_q;

  // Wakeup: waiting slots of held entries capture a matching broadcast;
  // scanning ports downward lets the lowest port index win.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = ent_q[i];
      for (int s = 0; s < 2; s++) begin
        if (ent_q[i].valid && !ent_q[i].src_rdy[s]) begin
          for (int k = NUM_WB - 1; k >= 0; k--) begin
            if (wb_valid[k] && (wb_prn[k*PRN_W +: PRN_W] == ent_q[i].src_prn[s])) begin
              woken[i].src_rdy[s]  = 1'b1;
              woken[i].src_data[s] = wb_data[k*64 +: 64];
            end
          end
        end
      end
    end
  end

  // Build the incoming entry, bypassing a same-cycle broadcast into waiting slots.
  always_comb begin
    new_ent          = '0;
    new_ent.valid    = 1'b1;
    new_ent.inst     = disp_inst;
    new_ent.id       = disp_inst_id;
    new_ent.out_prn  = disp_out_prn;
    new_ent.src_prn  = disp_src_prn;
    new_ent.src_rdy  = disp_src_rdy;
    new_ent.src_data = disp_src_data;
    for (int s = 0; s < 2; s++) begin
      if (!disp_src_rdy[s]) begin
        for (int k = NUM_WB - 1; k >= 0; k--) begin
          if (wb_valid[k] && (wb_prn[k*PRN_W +: PRN_W] == new_ent.src_prn[s])) begin
            new_ent.src_rdy[s]  = 1'b1;
            new_ent.src_data[s] = wb_data[k*64 +: 64];
          end
        end
      end
    end
  end

  // Select the lowest-index entry whose registered sources are both ready.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_ent   = '0;
    if (fu_ready && !flush) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (ent_q[i].valid && (&ent_q[i].src_rdy)) begin
          sel_found = 1'b1;
          sel_idx   = IW'(i);
          sel_ent   = ent_q[i];
        end
      end
    end
  end

  // Next queue contents: collapse over the issued slot, then append at the tail.
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      ent_d[i] = (sel_found && (IW'(i) >= sel_idx)) ? woken[i+1] : woken[i];
    end
    ent_d[DEPTH-1] = sel_found ? '0 : woken[DEPTH-1];
    count_after = count_q - CW'(sel_found);
    for (int i = 0; i < DEPTH; i++) begin
      if (accept && (count_after == CW'(i))) begin
        ent_d[i] = new_ent;
      end
    end
    count_d = count_after + CW'(accept);
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i] = '0;
      end
      count_d = '0;
    end
  end

  // Entry array and occupancy register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      count_q <= count_d;
    end
  end

  // Registered issue port: one-cycle valid pulse with the selected entry's fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss_valid_q   <= 1'b0;
      iss_inst_q    <= '0;
      iss_id_q      <= '0;
      iss_out_prn_q <= '0;
      iss_op_q      <= '0;
    end else begin
      iss_valid_q <= sel_found;
      if (sel_found) begin
        iss_inst_q    <= sel_ent.inst;
        iss_id_q      <= sel_ent.id;
        iss_out_prn_q <= sel_ent.out_prn;
        iss_op_q      <= sel_ent.src_data;
      end
    end
  end

endmodule

// File: tb/tb_rs_arith.sv
// tb_rs_arith: scoreboard bench for the arithmetic reservation station.
module tb_rs_arith;

  localparam int DEPTH  = 4;
  localparam int PRN_W  = 7;
  localparam int ID_W   = 6;
  localparam int NUM_WB = 2;

  typedef struct packed {
    logic                         dv;
    logic [31:0]                  inst;
    logic [ID_W-1:0]              id;
    logic [3*PRN_W-1:0]           oprn;
    logic [1:0][PRN_W-1:0]        sprn;
    logic [1:0]                   srdy;
    logic [1:0][63:0]             sdata;
    logic [NUM_WB-1:0]            wbv;
    logic [NUM_WB-1:0][PRN_W-1:0] wbprn;
    logic [NUM_WB-1:0][63:0]      wbdata;
    logic                         fu;
    logic                         fl;
  } stim_t;

  typedef struct {
    logic [31:0]           inst;
    logic [ID_W-1:0]       id;
    logic [3*PRN_W-1:0]    oprn;
    logic [1:0][PRN_W-1:0] sprn;
    logic [1:0]            rdy;
    logic [1:0][63:0]      data;
  } ment_t;

  typedef struct {
    int                 edgeNo;
    logic [31:0]        inst;
    logic [ID_W-1:0]    id;
    logic [3*PRN_W-1:0] oprn;
    logic [127:0]       op;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  stim_t cur = '0;

  logic               disp_ready;
  logic               iss_valid;
  logic [31:0]        iss_inst;
  logic [ID_W-1:0]    iss_inst_id;
  logic [3*PRN_W-1:0] iss_out_prn;
  logic [127:0]       iss_op;

  ment_t mq[$];
  exp_t  sb[$];
  exp_t  monExp;
  int    nChecks = 0;
  int    nFails  = 0;
  int    edgeCnt = 0;

  always #5 clk = ~clk;

  // Count rising edges so expectations can name the edge they belong to.
  always @(posedge clk) edgeCnt++;

  rs_arith #(.DEPTH(DEPTH), .PRN_W(PRN_W), .ID_W(ID_W), .NUM_WB(NUM_WB)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (cur.fl),
    .disp_valid   (cur.dv),
    .disp_ready   (disp_ready),
    .disp_inst    (cur.inst),
    .disp_inst_id (cur.id),
    .disp_out_prn (cur.oprn),
    .disp_src_prn (cur.sprn),
    .disp_src_rdy (cur.srdy),
    .disp_src_data(cur.sdata),
    .wb_valid     (cur.wbv),
    .wb_prn       (cur.wbprn),
    .wb_data      (cur.wbdata),
    .fu_ready     (cur.fu),
    .iss_valid    (iss_valid),
    .iss_inst     (iss_inst),
    .iss_inst_id  (iss_inst_id),
    .iss_out_prn  (iss_out_prn),
    .iss_op       (iss_op)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic stim_t idleStim(input logic fu);
    stim_t s = '0;
    s.fu = fu;
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s = '0;
    s.dv   = ($urandom_range(0, 3) != 0);
    s.inst = $urandom;
    s.id   = ID_W'($urandom);
    s.oprn = (3*PRN_W)'($urandom);
    for (int i = 0; i < 2; i++) begin
      s.sprn[i]  = PRN_W'($urandom_range(0, 7));
      s.sdata[i] = {$urandom, $urandom};
    end
    s.srdy = 2'($urandom);
    s.wbv  = NUM_WB'($urandom);
    for (int k = 0; k < NUM_WB; k++) begin
      s.wbprn[k]  = PRN_W'($urandom_range(0, 7));
      s.wbdata[k] = {$urandom, $urandom};
    end
    s.fu = ($urandom_range(0, 3) != 0);
    s.fl = ($urandom_range(0, 40) == 0);
    return s;
  endfunction

  // Drive one cycle of inputs and advance the reference model by that cycle.
  task automatic applyStimulus(input stim_t st);
    ment_t e;
    exp_t  x;
    bit    acc;
    int    sel;
    cur = st;
    checkOutput("disp_ready", disp_ready, (mq.size() < DEPTH));
    if (st.fl) begin
      mq.delete();
    end else begin
      acc = st.dv && (mq.size() < DEPTH);
      if (st.fu) begin
        sel = -1;
        foreach (mq[i]) if (sel < 0 && mq[i].rdy == 2'b11) sel = i;
        if (sel >= 0) begin
          x.edgeNo = edgeCnt + 1;
          x.inst   = mq[sel].inst;
          x.id     = mq[sel].id;
          x.oprn   = mq[sel].oprn;
          x.op     = mq[sel].data;
          sb.push_back(x);
          mq.delete(sel);
        end
      end
      foreach (mq[i]) begin
        for (int sl = 0; sl < 2; sl++) begin
          if (!mq[i].rdy[sl]) begin
            for (int k = 0; k < NUM_WB; k++) begin
              if (st.wbv[k] && st.wbprn[k] == mq[i].sprn[sl]) begin
                mq[i].rdy[sl]  = 1'b1;
                mq[i].data[sl] = st.wbdata[k];
                break;
              end
            end
          end
        end
      end
      if (acc) begin
        e.inst = st.inst;
        e.id   = st.id;
        e.oprn = st.oprn;
        e.sprn = st.sprn;
        e.rdy  = st.srdy;
        e.data = st.sdata;
        for (int sl = 0; sl < 2; sl++) begin
          if (!e.rdy[sl]) begin
            for (int k = 0; k < NUM_WB; k++) begin
              if (st.wbv[k] && st.wbprn[k] == e.sprn[sl]) begin
                e.rdy[sl]  = 1'b1;
                e.data[sl] = st.wbdata[k];
                break;
              end
            end
          end
        end
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every issue pulse is matched against the oldest expected issue.
  always @(negedge clk) begin
    if (rst) begin
      if (iss_valid) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_issue", iss_valid, 1'b0);
        end else begin
          monExp = sb.pop_front();
          checkOutput("issue_edge", edgeCnt, monExp.edgeNo);
          checkOutput("iss_inst", iss_inst, monExp.inst);
          checkOutput("iss_inst_id", iss_inst_id, monExp.id);
          checkOutput("iss_out_prn", iss_out_prn, monExp.oprn);
          checkOutput("iss_op", iss_op, monExp.op);
        end
      end else if (sb.size() > 0 && sb[0].edgeNo <= edgeCnt) begin
        monExp = sb.pop_front();
        checkOutput("missed_issue", iss_valid, 1'b1);
      end
    end
  end

  initial begin
    stim_t s;

    // Reset values.
    cur = idleStim(1'b0);
    #12;
    checkOutput("reset_iss_valid", iss_valid, 1'b0);
    checkOutput("reset_disp_ready", disp_ready, 1'b1);
    checkOutput("reset_iss_inst", iss_inst, 32'h0);
    checkOutput("reset_iss_op", iss_op, 128'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Ready ADD issues two cycles after dispatch.
    s = idleStim(1'b1);
    s.dv = 1'b1; s.inst = 32'h8B020020; s.id = 6'd5; s.oprn = 21'h00ABC;
    s.srdy = 2'b11; s.sdata[0] = 64'd5; s.sdata[1] = 64'd0;
    applyStimulus(s);
    for (int i = 0; i < 3; i++) applyStimulus(idleStim(1'b1));

    // SUBS waiting on PRN 9 in slot 1, woken by port 1.
    s = idleStim(1'b1);
    s.dv = 1'b1; s.inst = 32'hEB020020; s.id = 6'd6; s.oprn = 21'h01234;
    s.srdy = 2'b01; s.sdata[0] = 64'd77; s.sprn[1] = 7'd9;
    applyStimulus(s);
    applyStimulus(idleStim(1'b1));
    s = idleStim(1'b1);
    s.wbv = 2'b10; s.wbprn[1] = 7'd9; s.wbdata[1] = 64'h1234;
    applyStimulus(s);
    for (int i = 0; i < 3; i++) applyStimulus(idleStim(1'b1));

    // Fill to full with fu_ready low, then drain in order; full rejects even with an issue.
    for (int i = 1; i <= 4; i++) begin
      s = idleStim(1'b0);
      s.dv = 1'b1; s.inst = 32'hCB000000 | i; s.id = ID_W'(i); s.oprn = (3*PRN_W)'(i * 3);
      s.srdy = 2'b11; s.sdata[0] = 64'(i * 100); s.sdata[1] = 64'(i);
      applyStimulus(s);
    end
    s = idleStim(1'b1);
    s.dv = 1'b1; s.id = 6'd9; s.srdy = 2'b11;
    applyStimulus(s);
    for (int i = 0; i < 6; i++) applyStimulus(idleStim(1'b1));

    // Out-of-order readiness.
    s = idleStim(1'b1);
    s.dv = 1'b1; s.id = 6'd1; s.srdy = 2'b00; s.sprn[0] = 7'd10; s.sprn[1] = 7'd11;
    applyStimulus(s);
    s = idleStim(1'b1);
    s.dv = 1'b1; s.id = 6'd2; s.srdy = 2'b11; s.sdata[0] = 64'hAA; s.sdata[1] = 64'hBB;
    applyStimulus(s);
    applyStimulus(idleStim(1'b1));
    s = idleStim(1'b1);
    s.wbv = 2'b11; s.wbprn[0] = 7'd10; s.wbdata[0] = 64'h10; s.wbprn[1] = 7'd11; s.wbdata[1] = 64'h11;
    applyStimulus(s);
    for (int i = 0; i < 3; i++) applyStimulus(idleStim(1'b1));

    // Dispatch bypass with both ports matching PRN 3: port 0 must win.
    s = idleStim(1'b1);
    s.dv = 1'b1; s.id = 6'd12; s.srdy = 2'b00; s.sprn[0] = 7'd3; s.sprn[1] = 7'd3;
    s.wbv = 2'b11; s.wbprn[0] = 7'd3; s.wbdata[0] = 64'hC0DE; s.wbprn[1] = 7'd3; s.wbdata[1] = 64'hBAD;
    applyStimulus(s);
    for (int i = 0; i < 3; i++) applyStimulus(idleStim(1'b1));

    // Flush with three entries and an issue in flight.
    for (int i = 0; i < 3; i++) begin
      s = idleStim(1'b0);
      s.dv = 1'b1; s.id = ID_W'(20 + i); s.srdy = 2'b11; s.sdata[0] = 64'(i);
      applyStimulus(s);
    end
    applyStimulus(idleStim(1'b1));
    s = idleStim(1'b1);
    s.fl = 1'b1;
    applyStimulus(s);
    checkOutput("flush_iss_valid", iss_valid, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(idleStim(1'b1));

    // Reset mid-stream drops entries and the pending issue pulse at once.
    for (int i = 0; i < 3; i++) begin
      s = idleStim(1'b0);
      s.dv = 1'b1; s.id = ID_W'(30 + i); s.srdy = 2'b11; s.sdata[1] = 64'(i + 7);
      applyStimulus(s);
    end
    applyStimulus(idleStim(1'b1));
    rst = 1'b0;
    sb.delete();
    mq.delete();
    #1;
    checkOutput("midreset_iss_valid", iss_valid, 1'b0);
    checkOutput("midreset_disp_ready", disp_ready, 1'b1);
    checkOutput("midreset_iss_inst_id", iss_inst_id, 6'd0);
    checkOutput("midreset_iss_op", iss_op, 128'h0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(idleStim(1'b1));

    // Randomized traffic.
    for (int n = 0; n < 500; n++) applyStimulus(randStim());
    for (int i = 0; i < 4; i++) applyStimulus(idleStim(1'b1));
    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
